// File: rtl/bram_stream_port_pkg.sv
// Shared definitions for the block-RAM stream port: pointer-width helper and
// default sizing of the response buffer.
package bram_stream_port_pkg;

  // Bits needed to index 'depth' entries (minimum 1).
  function automatic int ptr_w(input int depth);
    int w;
    w = 0;
    while ((1 << w) < depth) w++;
    return (w < 1) ? 1 : w;
  endfunction

  localparam int RESP_DEPTH_DEF = 4;
  localparam int PTR_W          = ptr_w(RESP_DEPTH_DEF);
  localparam int CNT_W          = PTR_W + 1;

endpackage

// File: rtl/bram_stream_port_if.sv
// Request / RAM-pin / response bundle for bram_stream_port.
// master = requester + RAM side, slave = the port itself.
interface bram_stream_port_if #(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1
);
  logic                  REQ_VALID;
  logic                  REQ_READY;
  logic                  REQ_WE;
  logic [ADDR_WIDTH-1:0] REQ_ADDR;
  logic [DATA_WIDTH-1:0] REQ_DATA;
  logic [ADDR_WIDTH-1:0] RAM_ADDR;
  logic [DATA_WIDTH-1:0] RAM_DI;
  logic                  RAM_WE;
  logic                  RAM_RE;
  logic [DATA_WIDTH-1:0] RAM_DO;
  logic                  RESP_VALID;
  logic                  RESP_READY;
  logic [DATA_WIDTH-1:0] RESP_DATA;

  modport master (
    output REQ_VALID, REQ_WE, REQ_ADDR, REQ_DATA, RAM_DO, RESP_READY,
    input  REQ_READY, RAM_ADDR, RAM_DI, RAM_WE, RAM_RE, RESP_VALID, RESP_DATA
  );

  modport slave (
    input  REQ_VALID, REQ_WE, REQ_ADDR, REQ_DATA, RAM_DO, RESP_READY,
    output REQ_READY, RAM_ADDR, RAM_DI, RAM_WE, RAM_RE, RESP_VALID, RESP_DATA
  );
endinterface

// File: rtl/bram_stream_port_resp_fifo.sv
// Circular response buffer: register array, power-of-2 depth, pointers wrap
// naturally. Push into a full buffer cannot happen when the caller honours
// its credit rule; an assertion flags it if it ever does.
module bram_stream_resp_fifo import bram_stream_port_pkg::*; #(
  parameter int DATA_WIDTH = 1,
  parameter int DEPTH      = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [DATA_WIDTH-1:0]  data_i,
  input  logic                   pop_i,
  output logic [DATA_WIDTH-1:0]  data_o,
  output logic [ptr_w(DEPTH):0]  count_o,
  output logic                   empty_o
);
  localparam int PW = ptr_w(DEPTH);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
  logic [PW-1:0]                    head_q, tail_q;
  logic [PW:0]                      count_q, count_d;
  logic                             full;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[head_q];

  // Occupancy next state: simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: ;
    endcase
  end

  // Pointers and occupancy, cleared by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) tail_q <= tail_q + 1'b1;
      if (pop_i)  head_q <= head_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[tail_q] <= data_i;
  end

  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full));

endmodule

// File: rtl/bram_stream_port.sv
// Valid/ready front-end for a single-port block RAM with 1-cycle read latency.
// Credits (buffer occupancy + in-flight read) gate new requests so a read
// result always has a buffer slot; responses stream out in request order.
// Optional: define BRAM_STREAM_PORT_BYPASS_EN to forward RAM_DO straight to
// the response port when the buffer is empty (1-cycle read latency).
module bram_stream_port import bram_stream_port_pkg::*; #(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1,
  parameter int RESP_DEPTH = 4
) (
  input logic              CLK,
  input logic              RESET,
  bram_stream_port_if.slave bus
);
  localparam int PW = ptr_w(RESP_DEPTH);
  localparam int CW = PW + 1;

  logic                  pending_q, pending_d;
  logic                  fire;
  logic [CW-1:0]         count;
  logic [CW:0]           credits_used;
  logic                  fifo_push, fifo_pop, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;

  // Registered-only credit check: no path from valid/we/resp_ready.
  assign credits_used  = {1'b0, count} + (CW+1)'(pending_q);
  assign bus.REQ_READY = (credits_used < (CW+1)'(RESP_DEPTH));

  assign fire         = bus.REQ_VALID & bus.REQ_READY;
  assign bus.RAM_ADDR = ADDR_WIDTH'(bus.REQ_ADDR);
  assign bus.RAM_DI   = DATA_WIDTH'(bus.REQ_DATA);
  assign bus.RAM_WE   = fire &  bus.REQ_WE;
  assign bus.RAM_RE   = fire & ~bus.REQ_WE;
  assign pending_d    = fire & ~bus.REQ_WE;

`ifdef BRAM_STREAM_PORT_BYPASS_EN
  logic bypass;
  // Empty buffer with a read landing: present RAM_DO directly, and skip the
  // push if the consumer takes it this cycle.
  assign bypass         = pending_q & fifo_empty;
  assign fifo_push      = pending_q & ~(bypass & bus.RESP_READY);
  assign bus.RESP_VALID = ~fifo_empty | bypass;
  assign bus.RESP_DATA  = fifo_empty ? bus.RAM_DO : fifo_data;
`else
  assign fifo_push      = pending_q;
  assign bus.RESP_VALID = ~fifo_empty;
  assign bus.RESP_DATA  = fifo_data;
`endif

  assign fifo_pop = ~fifo_empty & bus.RESP_READY;

  // In-flight read flag: RAM_DO is valid the cycle after RAM_RE.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) pending_q <= 1'b0;
    else       pending_q <= pending_d;
  end

  bram_stream_resp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (RESP_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .push_i  (fifo_push),
    .data_i  (bus.RAM_DO),
    .pop_i   (fifo_pop),
    .data_o  (fifo_data),
    .count_o (count),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_bram_stream_port.sv
// Directed bench for bram_stream_port with a behavioural 16x8 RAM and an
// in-order response scoreboard.
module tb_bram_stream_port;

`ifdef BRAM_STREAM_PORT_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic CLK;
  logic RESET;
  int   n_chk = 0;
  int   n_err = 0;
  bit   rr_rand = 0;

  bram_stream_port_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus();

  bram_stream_port #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .RESP_DEPTH(4)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RAM model: preload data = address once, read-first, 1-cycle latency.
  logic [7:0] mem [16];
  bit         loaded = 0;
  always @(posedge CLK) begin
    if (!loaded) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'(i);
      bus.RAM_DO <= '0;
      loaded <= 1'b1;
    end else begin
      if (bus.RAM_WE) mem[bus.RAM_ADDR] <= bus.RAM_DI;
      if (bus.RAM_RE) bus.RAM_DO <= mem[bus.RAM_ADDR];
    end
  end

  // Scoreboard / protocol monitor sampled on the falling edge.
  logic [7:0] ref_mem [16];
  bit         ref_loaded = 0;
  logic [7:0] exp_q [$];
  bit         prev_stall = 0;
  logic [7:0] prev_data;
  int         resp_cnt = 0;
  int         re_cnt = 0;
  always @(negedge CLK) begin
    if (RESET) begin
      exp_q.delete();
      prev_stall = 0;
      if (!ref_loaded) begin
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'(i);
        ref_loaded = 1;
      end
    end else begin
      chk("we_re_excl", 32'(bus.RAM_WE & bus.RAM_RE), 0);
      if (bus.RAM_RE) re_cnt++;
      if (prev_stall) begin
        chk("hold_valid", 32'(bus.RESP_VALID), 1);
        chk("hold_data", 32'(bus.RESP_DATA), 32'(prev_data));
      end
      if (bus.RESP_VALID && bus.RESP_READY) begin
        if (exp_q.size() == 0) chk("spurious_resp", 32'(bus.RESP_VALID), 0);
        else begin
          chk("resp_data", 32'(bus.RESP_DATA), 32'(exp_q.pop_front()));
          resp_cnt++;
        end
      end
      prev_stall = bus.RESP_VALID && !bus.RESP_READY;
      prev_data  = bus.RESP_DATA;
      if (bus.REQ_VALID && bus.REQ_READY) begin
        if (bus.REQ_WE) ref_mem[bus.REQ_ADDR] = bus.REQ_DATA;
        else            exp_q.push_back(ref_mem[bus.REQ_ADDR]);
      end
    end
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
    if (rr_rand) bus.RESP_READY = 1'($urandom_range(0, 1));
  endtask

  // Offer one request and hold it until accepted (bounded).
  task automatic issue(input bit we, input logic [3:0] a, input logic [7:0] d);
    int n = 0;
    bus.REQ_VALID = 1'b1;
    bus.REQ_WE    = we;
    bus.REQ_ADDR  = a;
    bus.REQ_DATA  = d;
    @(negedge CLK);
    while (!bus.REQ_READY && n < 50) begin
      step();
      @(negedge CLK);
      n++;
    end
    if (n >= 50) chk("issue_timeout", 32'(bus.REQ_READY), 1);
    step();
    bus.REQ_VALID = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    int acc, re_base, resp_base;
    RESET          = 1'b1;
    bus.REQ_VALID  = 1'b0;
    bus.REQ_WE     = 1'b0;
    bus.REQ_ADDR   = '0;
    bus.REQ_DATA   = '0;
    bus.RESP_READY = 1'b1;

    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_resp_valid", 32'(bus.RESP_VALID), 0);
    chk("rst_ram_we", 32'(bus.RAM_WE), 0);
    chk("rst_ram_re", 32'(bus.RAM_RE), 0);
    chk("rst_req_ready", 32'(bus.REQ_READY), 1);
    @(posedge CLK); #1;
    RESET = 1'b0;

    // Write A5 to 3, then read 3
    bus.REQ_VALID = 1'b1; bus.REQ_WE = 1'b1; bus.REQ_ADDR = 4'd3; bus.REQ_DATA = 8'hA5;
    @(negedge CLK);
    chk("t1_wr_we", 32'(bus.RAM_WE), 1);
    chk("t1_wr_re", 32'(bus.RAM_RE), 0);
    chk("t1_wr_addr", 32'(bus.RAM_ADDR), 3);
    chk("t1_wr_di", 32'(bus.RAM_DI), 32'hA5);
    step();
    bus.REQ_WE = 1'b0;
    @(negedge CLK);
    chk("t1_rd_re", 32'(bus.RAM_RE), 1);
    chk("t1_rd_we", 32'(bus.RAM_WE), 0);
    step();
    bus.REQ_VALID = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge CLK);
      chk("t1_resp_valid", 32'(bus.RESP_VALID), 32'(k == LAT));
      if (k == LAT) chk("t1_resp_data", 32'(bus.RESP_DATA), 32'hA5);
      step();
    end
    issue(1'b1, 4'd3, 8'd3);

    // 16 back-to-back reads, one response per cycle
    for (int i = 0; i < 16 + LAT; i++) begin
      if (i < 16) begin
        bus.REQ_VALID = 1'b1; bus.REQ_WE = 1'b0; bus.REQ_ADDR = 4'(i);
      end else bus.REQ_VALID = 1'b0;
      @(negedge CLK);
      if (i < 16) chk("b2b_req_ready", 32'(bus.REQ_READY), 1);
      if (i >= LAT) begin
        chk("b2b_resp_valid", 32'(bus.RESP_VALID), 1);
        chk("b2b_resp_data", 32'(bus.RESP_DATA), 32'(i - LAT));
      end
      step();
    end
    drain("b2b_drain");

    // Consumer stalled: only 4 reads accepted, then lossless drain
    bus.RESP_READY = 1'b0;
    acc = 0; re_base = re_cnt; resp_base = resp_cnt;
    for (int i = 0; i < 8; i++) begin
      bus.REQ_VALID = 1'b1; bus.REQ_WE = 1'b0; bus.REQ_ADDR = 4'(acc);
      @(negedge CLK);
      if (bus.REQ_READY) acc++;
      step();
    end
    bus.REQ_VALID = 1'b0;
    @(negedge CLK);
    chk("stall_accepted", acc, 4);
    chk("stall_req_ready", 32'(bus.REQ_READY), 0);
    chk("stall_re_count", re_cnt - re_base, 4);
    step();
    bus.RESP_READY = 1'b1;
    drain("stall_drain");
    chk("stall_resp_count", resp_cnt - resp_base, 4);

    // Push and pop together at 3/4 occupancy
    bus.RESP_READY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.REQ_VALID = 1'b1; bus.REQ_WE = 1'b0; bus.REQ_ADDR = 4'(8 + i);
      @(negedge CLK);
      chk("pp_req_ready", 32'(bus.REQ_READY), 1);
      step();
    end
    bus.RESP_READY = 1'b1;
    bus.REQ_ADDR = 4'd12;
    @(negedge CLK);
    chk("pp_full_credit", 32'(bus.REQ_READY), 0);
    chk("pp_count_a", 32'(dut.u_fifo.count_q), 3);
    chk("pp_head_a", 32'(bus.RESP_DATA), 8);
    step();
    @(negedge CLK);
    chk("pp_count_b", 32'(dut.u_fifo.count_q), 3);
    chk("pp_req_ready_b", 32'(bus.REQ_READY), 1);
    chk("pp_head_b", 32'(bus.RESP_DATA), 9);
    step();
    bus.REQ_VALID = 1'b0;
    issue(1'b0, 4'd13, 8'd0);
    drain("pp_drain");

    // Random mix with 50% consumer readiness
    rr_rand = 1;
    for (int i = 0; i < 200; i++)
      issue(($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
    rr_rand = 0;
    bus.RESP_READY = 1'b1;
    drain("rand_drain");

    // Asynchronous reset with one read in flight and two buffered
    issue(1'b1, 4'd5, 8'hC3);
    bus.RESP_READY = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      bus.REQ_VALID = 1'b1; bus.REQ_WE = 1'b0; bus.REQ_ADDR = 4'(i);
      @(negedge CLK);
      step();
    end
    bus.REQ_VALID = 1'b0;
    #2;
    chk("mr_pending_pre", 32'(dut.pending_q), 1);
    chk("mr_count_pre", 32'(dut.u_fifo.count_q), 2);
    RESET = 1'b1;
    #1;
    chk("mr_resp_valid", 32'(bus.RESP_VALID), 0);
    chk("mr_req_ready", 32'(bus.REQ_READY), 1);
    @(posedge CLK); #1;
    RESET = 1'b0;
    bus.RESP_READY = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      chk("mr_no_stale", 32'(bus.RESP_VALID), 0);
      step();
    end
    bus.REQ_VALID = 1'b1; bus.REQ_WE = 1'b0; bus.REQ_ADDR = 4'd5;
    @(negedge CLK);
    chk("mr_rd_ready", 32'(bus.REQ_READY), 1);
    step();
    bus.REQ_VALID = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge CLK);
      chk("mr_resp_valid_new", 32'(bus.RESP_VALID), 32'(k == LAT));
      if (k == LAT) chk("mr_resp_data_new", 32'(bus.RESP_DATA), 32'hC3);
      step();
    end
    drain("mr_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
